id_ex_decode_stage: RTL
=======================

// Module: id_ex_decode_stage
// PURPOSE
//  Registered MIPS decode stage for the forwarding pipeline. Each cycle it decodes the ID-stage
//  instruction word into ALU op, data-memory controls, register selects and an extended immediate,
//  then latches the result into the ID/EX register. It also detects load-use hazards against the
//  instruction already in EX, stalls ID and inserts bubbles, and honours redirect flushes.
//  A saturating counter records stall cycles for performance checks.
// PARAMETERS
//  DATA_W    32   width of ex_imm_ext (>=16)
//  ALUOP_W   4    width of ex_aluop (>=4)
//  CNT_W     16   width of stall_cnt
//  SYS_RA    5'd2 ra forced for syscall (op=0, funct=0x0c)
//  SYS_RB    5'd4 rb forced for syscall
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  id_valid    in   1        id_ir holds a real instruction
//  id_ir       in   32       instruction word in ID
//  flush       in   1        redirect: kill the ID instruction this cycle
//  id_stall    out  1        combinational; 1 = hold PC/IF-ID, ID instr not accepted
//  ex_valid    out  1        ID/EX holds a real instruction
//  ex_aluop    out  ALUOP_W  ALU operation
//  ex_dmload   out  1        load (op 0x23, 0x24)
//  ex_dmstr    out  1        store (op 0x2b)
//  ex_dmsel    out  1        memory access (load or store)
//  ex_ra/ex_rb out  5        register-file read selects
//  ex_rs/ex_rt out  5        IR[25:21] / IR[20:16]
//  ex_op/ex_funct out 6      IR[31:26] / IR[5:0]
//  ex_imm_ext  out  DATA_W   extended IR[15:0]
//  stall_cnt   out  CNT_W    number of stall cycles since reset
// BEHAVIOUR
//  Decode (combinational, ID side):
//   op=0: aluop from funct: 02->2 03->1 06->2 20,21->5 22->6 24->7 25->8 26->9 27->A 2A->B 2B->C, else 0.
//   op!=0: aluop from op: 01->B 04,05->9 08,09->5 0A->B 0C->7 0D->8 0E->9 2B->5, else 0. Zero-extend to ALUOP_W.
//   ra/rb = SYS_RA/SYS_RB when op=0 and funct=0x0c; otherwise ra=rs, rb=rt.
//   imm_ext: zero-extended for op 0C/0D/0E; sign-extended for all other ops.
//  Hazard: haz = ex_valid & ex_dmload & id_valid & ((ex_rt==ra & ra!=0) | (ex_rt==rb & rb!=0)).
//   id_stall = haz & ~flush.
//  Register update (every posedge clk), priority:
//   1 rst    : every ex_* output = 0, ex_valid=0, stall_cnt=0.
//   2 flush  : bubble (all ex_* = 0, ex_valid=0). Flush overrides a simultaneous hazard.
//   3 haz    : bubble; the upstream stage holds id_ir, so the instruction decodes again next cycle.
//   4 else   : latch the decode; ex_valid=id_valid. If id_valid=0, ex_* controls are latched as 0.
//  Latency: one cycle from ID to ex_* outputs. A load-use pair costs exactly one bubble, because
//   after the bubble ex_valid=0 and the hazard clears.
//  stall_cnt: +1 on each cycle id_stall=1 and rst=0; saturates at all-ones with no wrap.
//  Reset asserted mid-stall drops the stall on the next edge; id_stall follows ex_valid and goes to 0.
//  No storage beyond the ID/EX register and the counter; no X may propagate from reset.
// TESTING
//  T1 reset: rst=1 for 2 cycles with id_ir=0x8C430004 -> all ex_*=0, stall_cnt=0, id_stall=0.
//  T2 R-type: id_ir=0x00432020 (add) valid -> next cycle ex_aluop=5, ex_ra=2, ex_rb=3, ex_dmsel=0, ex_valid=1.
//  T3 load-use: 0x8C430004 (lw $3) then 0x00632020 -> id_stall=1 for 1 cycle, one bubble, add enters EX on the
//     following cycle, stall_cnt=1.
//  T4 flush vs hazard: repeat T3 with flush=1 in the hazard cycle -> id_stall=0, bubble, stall_cnt unchanged.
//  T5 syscall/imm: 0x0000000C -> ex_ra=2, ex_rb=4; 0x3402FFFF (ori) -> ex_imm_ext=0x0000FFFF, aluop=8;
//     0x2002FFFF (addi) -> ex_imm_ext=0xFFFFFFFF.
//  T6 saturation: CNT_W=2, force 5 consecutive stalls -> stall_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_decode_stage.sv
// id_ex_decode_stage
// Registered MIPS decode stage: decodes the ID instruction word, detects
// load-use hazards against the instruction held in EX, inserts bubbles on
// hazards or redirect flushes, and counts stall cycles with a saturating
// counter. All ex_* outputs come straight from the ID/EX register.
module id_ex_decode_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16,
  parameter logic [4:0]  SYS_RA  = 5'd2,
  parameter logic [4:0]  SYS_RB  = 5'd4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [31:0]        id_ir,
  input  logic               flush,
  output logic               id_stall,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_dmload,
  output logic               ex_dmstr,
  output logic               ex_dmsel,
  output logic [4:0]         ex_ra,
  output logic [4:0]         ex_rb,
  output logic [4:0]         ex_rs,
  output logic [4:0]         ex_rt,
  output logic [5:0]         ex_op,
  output logic [5:0]         ex_funct,
  output logic [DATA_W-1:0]  ex_imm_ext,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic               valid;
    logic [ALUOP_W-1:0] aluop;
    logic               dmload;
    logic               dmstr;
    logic               dmsel;
    logic [4:0]         ra;
    logic [4:0]         rb;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic [DATA_W-1:0]  imm_ext;
  } ex_reg_t;

  ex_reg_t          ex_q;
  ex_reg_t          ex_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic [5:0]         dec_op;
  logic [5:0]         dec_funct;
  logic [4:0]         dec_rs;
  logic [4:0]         dec_rt;
  logic [4:0]         dec_ra;
  logic [4:0]         dec_rb;
  logic [3:0]         dec_alu4;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_load;
  logic               dec_store;
  logic               dec_syscall;
  logic               dec_zext;
  logic [DATA_W-1:0]  dec_imm;
  logic               haz;

  assign dec_op      = id_ir[31:26];
  assign dec_funct   = id_ir[5:0];
  assign dec_rs      = id_ir[25:21];
  assign dec_rt      = id_ir[20:16];
  assign dec_load    = (dec_op == 6'h23) || (dec_op == 6'h24);
  assign dec_store   = (dec_op == 6'h2b);
  assign dec_syscall = (dec_op == 6'h00) && (dec_funct == 6'h0c);
  assign dec_zext    = (dec_op == 6'h0c) || (dec_op == 6'h0d) || (dec_op == 6'h0e);

  // ALU operation: R-type selects on funct, everything else on the opcode.
  always_comb begin
    dec_alu4 = 4'h0;
    if (dec_op == 6'h00) begin
      case (dec_funct)
        6'h02:        dec_alu4 = 4'h2;
        6'h03:        dec_alu4 = 4'h1;
        6'h06:        dec_alu4 = 4'h2;
        6'h20, 6'h21: dec_alu4 = 4'h5;
        6'h22:        dec_alu4 = 4'h6;
        6'h24:        dec_alu4 = 4'h7;
        6'h25:        dec_alu4 = 4'h8;
        6'h26:        dec_alu4 = 4'h9;
        6'h27:        dec_alu4 = 4'ha;
        6'h2a:        dec_alu4 = 4'hb;
        6'h2b:        dec_alu4 = 4'hc;
        default:      dec_alu4 = 4'h0;
      endcase
    end else begin
      case (dec_op)
        6'h01:        dec_alu4 = 4'hb;
        6'h04, 6'h05: dec_alu4 = 4'h9;
        6'h08, 6'h09: dec_alu4 = 4'h5;
        6'h0a:        dec_alu4 = 4'hb;
        6'h0c:        dec_alu4 = 4'h7;
        6'h0d:        dec_alu4 = 4'h8;
        6'h0e:        dec_alu4 = 4'h9;
        6'h2b:        dec_alu4 = 4'h5;
        default:      dec_alu4 = 4'h0;
      endcase
    end
  end

  // Widen the 4-bit ALU code to the configured output width.
  always_comb begin
    dec_aluop      = '0;
    dec_aluop[3:0] = dec_alu4;
  end

  // Register read selects; syscall reads its fixed argument registers.
  always_comb begin
    dec_ra = dec_rs;
    dec_rb = dec_rt;
    if (dec_syscall) begin
      dec_ra = SYS_RA;
      dec_rb = SYS_RB;
    end
  end

  // Immediate: logical ops zero-extend, all others sign-extend.
  always_comb begin
    dec_imm       = {DATA_W{id_ir[15] & ~dec_zext}};
    dec_imm[15:0] = id_ir[15:0];
  end

  // A load in EX whose destination is read by the ID instruction must wait one cycle.
  assign haz = ex_q.valid & ex_q.dmload & id_valid &
               (((ex_q.rt == dec_ra) && (dec_ra != 5'd0)) ||
                ((ex_q.rt == dec_rb) && (dec_rb != 5'd0)));

  assign id_stall = haz & ~flush;

  // Next ID/EX contents and stall count; flush and hazard both produce a bubble.
  always_comb begin
    ex_d        = '0;
    stall_cnt_d = stall_cnt_q;
    if (!flush && !haz && id_valid) begin
      ex_d.valid   = 1'b1;
      ex_d.aluop   = dec_aluop;
      ex_d.dmload  = dec_load;
      ex_d.dmstr   = dec_store;
      ex_d.dmsel   = dec_load | dec_store;
      ex_d.ra      = dec_ra;
      ex_d.rb      = dec_rb;
      ex_d.rs      = dec_rs;
      ex_d.rt      = dec_rt;
      ex_d.op      = dec_op;
      ex_d.funct   = dec_funct;
      ex_d.imm_ext = dec_imm;
    end
    if (id_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // ID/EX register and stall counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_aluop   = ex_q.aluop;
  assign ex_dmload  = ex_q.dmload;
  assign ex_dmstr   = ex_q.dmstr;
  assign ex_dmsel   = ex_q.dmsel;
  assign ex_ra      = ex_q.ra;
  assign ex_rb      = ex_q.rb;
  assign ex_rs      = ex_q.rs;
  assign ex_rt      = ex_q.rt;
  assign ex_op      = ex_q.op;
  assign ex_funct   = ex_q.funct;
  assign ex_imm_ext = ex_q.imm_ext;
  assign stall_cnt  = stall_cnt_q;

endmodule
